fetch_queue: RTL



---
 rtl/fetch_queue.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular decoupling buffer between the fetch and decode stages.
// Define FETCH_QUEUE_BYPASS_EN to hand an incoming word straight to decode when empty.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH-1:0]        instruc_in,
   input  logic [WIDTH-1:0]        seq_PC_in,
   input  logic                    fetch_valid,
   output logic                    en_PC,
   input  logic                    flush,
   input  logic                    dec_ready,
   output logic                    dec_valid,
   output logic [WIDTH-1:0]        instruc_out,
   output logic [WIDTH-1:0]        seq_PC_out,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [WIDTH-1:0] NOP = WIDTH'(16'h0800);

   logic [WIDTH-1:0] instr_mem_q [DEPTH];
   logic [WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [AW-1:0]    head_q, head_d;
   logic [AW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             not_empty;
   logic             push;
   logic             store;
   logic             pop;
   logic             byp;

   always_comb begin
      not_empty = (count_q != '0);
      en_PC     = (count_q < CW'(DEPTH)) && !flush && rst;
      push      = fetch_valid && en_PC;
      pop       = not_empty && dec_ready && !flush;
`ifdef FETCH_QUEUE_BYPASS_EN
      byp       = !not_empty && fetch_valid && !flush && rst;
      // a bypassed word taken by decode this cycle never lands in storage
      store     = push && !(byp && dec_ready);
`else
      byp       = 1'b0;
      store     = push;
`endif
      dec_valid   = not_empty || byp;
      instruc_out = NOP;
      seq_PC_out  = '0;
      if (not_empty) begin
         instruc_out = instr_mem_q[head_q];
         seq_PC_out  = pc_mem_q[head_q];
      end else if (byp) begin
         instruc_out = instruc_in;
         seq_PC_out  = seq_PC_in;
      end
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop)   head_d = head_q + AW'(1);
         if (store) tail_d = tail_q + AW'(1);
         count_d = count_q + CW'(store) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (store) begin
         instr_mem_q[tail_q] <= instruc_in;
         pc_mem_q[tail_q]    <= seq_PC_in;
      end
   end

   assign count = count_q;

endmodule
